dma_request_scheduler: RTL and testbench
========================================

// Module: dma_request_scheduler
// PURPOSE
//  Shares the single dma_controller engine between NREQ hardware requesters (SPDIF Rx/Tx, loader).
//  Round-robin arbitrates transfer requests and programs the engine over its Wishbone slave port.
//  Writes the RD, WR and START/COUNT registers, waits for dma_irq, then pulses done to the granted requester.
//  Sits between requesters and dma_controller; the CPU does not program the engine while this block is active.
// PARAMETERS
//  NREQ        4     number of requesters (2..8)
//  DMA_AWIDTH  7     engine word-address width; count field is DMA_AWIDTH+1 bits
//  TIMEOUT_CYC 1024  cycles in WAIT_IRQ before abandoning the transfer
// PORTS
//  clk_i        in   1               system clock; all logic on posedge
//  rst_i        in   1               synchronous reset, active-high
//  req_i        in   NREQ            per-requester transfer request level
//  rd_dev_i     in   2*NREQ          source device, requester k at [2k+1:2k]
//  rd_adr_i     in   DMA_AWIDTH*NREQ source start address, packed per requester
//  wr_dev_i     in   2*NREQ          destination device
//  wr_adr_i     in   DMA_AWIDTH*NREQ destination start address
//  count_i      in   (DMA_AWIDTH+1)*NREQ transfer count, passed to engine unchanged
//  done_o       out  NREQ            1-cycle pulse to granted requester on completion
//  err_o        out  NREQ            1-cycle pulse to granted requester on timeout
//  busy_o       out  1               high from grant until done/err pulse
//  gnt_idx_o    out  3               index of current/last granted requester
//  wbm_adr_o    out  16              Wishbone master address (0x0 RD, 0x4 WR, 0x8 START/COUNT)
//  wbm_dat_o    out  32              Wishbone write data
//  wbm_we_o     out  1               always 1 during a cycle (write-only master)
//  wbm_sel_o    out  4               4'hF during a cycle, else 0
//  wbm_cyc_o    out  1               bus cycle
//  wbm_stb_o    out  1               strobe; equals wbm_cyc_o
//  wbm_ack_i    in   1               slave acknowledge
//  dma_irq_i    in   1               engine done pulse
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, RR pointer 0, timeout counter 0.
//  FSM: IDLE -> PROG_RD -> PROG_WR -> PROG_GO -> WAIT_IRQ -> IDLE.
//  IDLE: if |req_i, grant first requester at or after RR pointer; latch its fields; busy_o=1; next PROG_RD.
//  Grant is registered: PROG_RD's bus cycle starts the cycle after the grant.
//  RR pointer updates to (granted+1) mod NREQ at grant time.
//  PROG_RD: write {rd_dev,28'b0 region,rd_adr} to 0x0; PROG_WR: same layout to 0x4.
//  PROG_GO: write {1'b1, zeros, count} to 0x8 (bit31 = start).
//  Each bus write: cyc/stb/we/sel held until the first cycle wbm_ack_i=1; advance state on that cycle; cyc drops next cycle.
//  Minimum 1 cycle per write; back-to-back writes have one idle cycle between them.
//  WAIT_IRQ: counter increments each cycle. On dma_irq_i: done_o[gnt]=1 for one cycle, busy_o=0, back to IDLE.
//  Timeout at TIMEOUT_CYC-1: err_o[gnt] pulse, busy_o=0, IDLE.
//  Stray dma_irq_i outside WAIT_IRQ is ignored.
//  Requests are levels: a requester holds req_i until done/err; deasserting mid-transfer does not abort.
//  A re-asserted request is re-arbitrated in IDLE the cycle after the done pulse (no same-cycle regrant).
//  Simultaneous requests: the lowest index at or after the pointer wins.
//  Reset mid-transfer: block returns to IDLE immediately; the engine is not aborted and its irq is ignored.
//  Latched fields are stable from grant to done; requester inputs may change freely after the grant.
// STRUCTURE
//  dma_sched_pkg: register offsets (REG_RD=16'h0, REG_WR=16'h4, REG_GO=16'h8), state encoding, device codes
//  (0 SPDIF Rx, 1 SPDIF Tx, 2 IMEM, 3 MainMem), START_BIT=31.
//  Sub-module rr_arbiter #(NREQ): req vector + pointer -> one-hot grant + index; purely combinational.
//  Top holds the FSM, field latch, Wishbone master and timeout counter.
// TESTING
//  Single req_i[1], rd=2/0x10, wr=3/0x20, count 8 -> writes 0x0=0x80000010, 0x4=0xC0000020, 0x8=0x80000008; irq -> done_o=4'b0010.
//  req_i=4'b1111 held -> grants in order 0,1,2,3,0; each done pulse goes to the matching index.
//  Slave ack delayed 3 cycles per write -> cyc/stb/adr/dat stable until ack; exactly 3 writes issued.
//  No dma_irq_i, TIMEOUT_CYC=16 -> err_o pulse 16 cycles after entering WAIT_IRQ; busy_o drops; next request served.
//  rst_i asserted in WAIT_IRQ -> outputs 0 next cycle; a later irq produces no done; pointer resets to 0.
//  Stray dma_irq_i in IDLE/PROG states -> no done_o; requester deasserts after grant -> transfer still completes with done.

Source files
------------

// File: rtl/dma_sched_pkg.sv
// Shared constants, state encoding and word packing helpers
// for the DMA request scheduler.
package dma_sched_pkg;

  localparam logic [15:0] REG_RD = 16'h0;
  localparam logic [15:0] REG_WR = 16'h4;
  localparam logic [15:0] REG_GO = 16'h8;

  localparam int START_BIT = 31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROG_RD,
    S_PROG_WR,
    S_PROG_GO,
    S_WAIT_IRQ
  } state_t;

  typedef enum logic [1:0] {
    DEV_SPDIF_RX = 2'd0,
    DEV_SPDIF_TX = 2'd1,
    DEV_IMEM     = 2'd2,
    DEV_MAINMEM  = 2'd3
  } dev_t;

  // Device code in the top two bits, word address zero-extended below.
  function automatic logic [31:0] pack_ptr(
    input logic [1:0]  dev,
    input logic [29:0] adr
  );
    return {dev, adr};
  endfunction

  function automatic logic [31:0] pack_go(
    input logic [30:0] cnt
  );
    logic [31:0] w;
    w = {1'b0, cnt};
    w[START_BIT] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/dma_request_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after
// the pointer wins. Ports: i_req, i_ptr -> o_gnt (one-hot), o_idx, o_valid.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [2:0]      i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [2:0]      o_idx,
  output logic            o_valid
);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [3:0]        w_sum;

  // Rotate so bit 0 of w_rot is the requester under the pointer.
  assign w_dbl = {i_req, i_req};
  assign w_rot = NREQ'(w_dbl >> i_ptr);

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!o_valid && w_rot[j]) begin
        w_sum = {1'b0, i_ptr} + 4'(j);
        if (w_sum >= 4'(NREQ))
          w_sum = w_sum - 4'(NREQ);
        o_valid = 1'b1;
        o_idx   = w_sum[2:0];
        o_gnt   = NREQ'(1) << w_sum;
      end
    end
  end

endmodule

// File: rtl/dma_request_scheduler.sv
// Shares one DMA engine between NREQ requesters: round-robin grant,
// program RD/WR/GO over a write-only Wishbone master, wait for irq,
// then pulse done_o (or err_o on timeout) to the granted requester.
// Ports: clk_i/rst_i, req_i + packed per-requester fields,
// done_o/err_o/busy_o/gnt_idx_o, wbm_* master, dma_irq_i.
module dma_request_scheduler
  import dma_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DMA_AWIDTH  = 7,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NREQ-1:0]              req_i,
  input  logic [2*NREQ-1:0]            rd_dev_i,
  input  logic [DMA_AWIDTH*NREQ-1:0]   rd_adr_i,
  input  logic [2*NREQ-1:0]            wr_dev_i,
  input  logic [DMA_AWIDTH*NREQ-1:0]   wr_adr_i,
  input  logic [(DMA_AWIDTH+1)*NREQ-1:0] count_i,
  output logic [NREQ-1:0]              done_o,
  output logic [NREQ-1:0]              err_o,
  output logic                         busy_o,
  output logic [2:0]                   gnt_idx_o,
  output logic [15:0]                  wbm_adr_o,
  output logic [31:0]                  wbm_dat_o,
  output logic                         wbm_we_o,
  output logic [3:0]                   wbm_sel_o,
  output logic                         wbm_cyc_o,
  output logic                         wbm_stb_o,
  input  logic                         wbm_ack_i,
  input  logic                         dma_irq_i
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  state_t          r_state;
  logic [2:0]      r_ptr;
  logic [2:0]      r_gnt;
  logic [NREQ-1:0] r_gnt_oh;
  logic [NREQ-1:0] r_done;
  logic [NREQ-1:0] r_err;
  logic            r_busy;
  logic            r_cyc;
  logic [15:0]     r_adr;
  logic [31:0]     r_dat;
  logic [31:0]     r_wr_word;
  logic [31:0]     r_go_word;
  logic [TW-1:0]   r_cnt;

  logic [NREQ-1:0]     w_gnt_oh;
  logic [2:0]          w_idx;
  logic                w_valid;
  logic [2:0]          w_nxt_ptr;
  logic [1:0]          w_rd_dev;
  logic [1:0]          w_wr_dev;
  logic [DMA_AWIDTH-1:0] w_rd_adr;
  logic [DMA_AWIDTH-1:0] w_wr_adr;
  logic [DMA_AWIDTH:0]   w_cnt;
  logic                w_pulse;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .i_req  (req_i),
    .i_ptr  (r_ptr),
    .o_gnt  (w_gnt_oh),
    .o_idx  (w_idx),
    .o_valid(w_valid)
  );

  assign w_rd_dev = rd_dev_i[2*int'(w_idx) +: 2];
  assign w_wr_dev = wr_dev_i[2*int'(w_idx) +: 2];
  assign w_rd_adr = rd_adr_i[DMA_AWIDTH*int'(w_idx) +: DMA_AWIDTH];
  assign w_wr_adr = wr_adr_i[DMA_AWIDTH*int'(w_idx) +: DMA_AWIDTH];
  assign w_cnt    = count_i[(DMA_AWIDTH+1)*int'(w_idx) +: DMA_AWIDTH+1];

  assign w_nxt_ptr = (w_idx == 3'(NREQ-1)) ? 3'd0 : w_idx + 3'd1;

  // While done/err is pulsing the finishing requester still holds its
  // level, so arbitration waits one cycle to avoid a bogus regrant.
  assign w_pulse = |r_done || |r_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_gnt_oh  <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_busy    <= 1'b0;
      r_cyc     <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_wr_word <= '0;
      r_go_word <= '0;
      r_cnt     <= '0;
    end else begin
      r_done <= '0;
      r_err  <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_valid && !w_pulse) begin
            r_state   <= S_PROG_RD;
            r_gnt     <= w_idx;
            r_gnt_oh  <= w_gnt_oh;
            r_ptr     <= w_nxt_ptr;
            r_busy    <= 1'b1;
            r_cyc     <= 1'b1;
            r_adr     <= REG_RD;
            r_dat     <= pack_ptr(w_rd_dev, 30'(w_rd_adr));
            r_wr_word <= pack_ptr(w_wr_dev, 30'(w_wr_adr));
            r_go_word <= pack_go(31'(w_cnt));
          end
        end
        S_PROG_RD: begin
          if (r_cyc && wbm_ack_i) begin
            r_cyc   <= 1'b0;
            r_state <= S_PROG_WR;
          end
        end
        S_PROG_WR: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_adr <= REG_WR;
            r_dat <= r_wr_word;
          end else if (wbm_ack_i) begin
            r_cyc   <= 1'b0;
            r_state <= S_PROG_GO;
          end
        end
        S_PROG_GO: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_adr <= REG_GO;
            r_dat <= r_go_word;
          end else if (wbm_ack_i) begin
            r_cyc   <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_WAIT_IRQ;
          end
        end
        S_WAIT_IRQ: begin
          if (dma_irq_i) begin
            r_done  <= r_gnt_oh;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == TW'(TIMEOUT_CYC-1)) begin
            r_err   <= r_gnt_oh;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done_o    = r_done;
  assign err_o     = r_err;
  assign busy_o    = r_busy;
  assign gnt_idx_o = r_gnt;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_cyc;
  assign wbm_sel_o = {4{r_cyc}};

endmodule

// File: tb/tb_dma_request_scheduler.sv
// Self-checking bench for dma_request_scheduler with a round-robin
// reference model, a scripted Wishbone slave and an irq driver.
module tb_dma_request_scheduler;

  localparam int NREQ = 4;
  localparam int AW   = 7;
  localparam int TO   = 16;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [7:0]  rd_dev_i, wr_dev_i;
  logic [27:0] rd_adr_i, wr_adr_i;
  logic [31:0] count_i;
  logic [3:0]  done_o, err_o;
  logic        busy_o;
  logic [2:0]  gnt_idx_o;
  logic [15:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i, dma_irq_i;

  always #5 clk = ~clk;

  dma_request_scheduler #(
    .NREQ(NREQ), .DMA_AWIDTH(AW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i),
    .rd_dev_i(rd_dev_i), .rd_adr_i(rd_adr_i),
    .wr_dev_i(wr_dev_i), .wr_adr_i(wr_adr_i),
    .count_i(count_i), .done_o(done_o), .err_o(err_o),
    .busy_o(busy_o), .gnt_idx_o(gnt_idx_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_ack_i(wbm_ack_i), .dma_irq_i(dma_irq_i)
  );

  int total = 0;
  int bad = 0;
  int ptr = 0;

  logic [1:0] f_rdv[4], f_wrv[4];
  logic [6:0] f_rda[4], f_wra[4];
  logic [7:0] f_cnt[4];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fields;
    for (int i = 0; i < 4; i++) begin
      rd_dev_i[2*i +: 2] = f_rdv[i];
      wr_dev_i[2*i +: 2] = f_wrv[i];
      rd_adr_i[7*i +: 7] = f_rda[i];
      wr_adr_i[7*i +: 7] = f_wra[i];
      count_i[8*i +: 8]  = f_cnt[i];
    end
  endtask

  task automatic rand_fields;
    for (int i = 0; i < 4; i++) begin
      f_rdv[i] = 2'($urandom);
      f_wrv[i] = 2'($urandom);
      f_rda[i] = 7'($urandom);
      f_wra[i] = 7'($urandom);
      f_cnt[i] = 8'($urandom);
    end
    drive_fields();
  endtask

  // Reference round robin: first set request at or after the pointer.
  function automatic int pick(input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic serve_write(input int gap, input int dly,
                             input bit stray, input logic [15:0] ea,
                             input logic [31:0] ed, input string nm);
    int n;
    n = 0;
    dma_irq_i = stray;
    while (!wbm_cyc_o && n < 6) begin
      step();
      n++;
    end
    total++;
    if (n !== gap)
      begin bad++; $display("FAIL %s_gap got=%0d exp=%0d", nm, n, gap); end
    if (!wbm_cyc_o) begin
      dma_irq_i = 1'b0;
      return;
    end
    total++;
    if ({wbm_we_o, wbm_stb_o, wbm_sel_o} !== 6'b111111) begin
      bad++;
      $display("FAIL %s_ctl got=%b exp=111111", nm,
               {wbm_we_o, wbm_stb_o, wbm_sel_o});
    end
    total++;
    if (wbm_adr_o !== ea)
      begin bad++; $display("FAIL %s_adr got=%h exp=%h", nm, wbm_adr_o, ea); end
    total++;
    if (wbm_dat_o !== ed)
      begin bad++; $display("FAIL %s_dat got=%h exp=%h", nm, wbm_dat_o, ed); end
    repeat (dly) begin
      step();
      total++;
      if ({wbm_cyc_o, wbm_adr_o, wbm_dat_o} !== {1'b1, ea, ed}) begin
        bad++;
        $display("FAIL %s_hold got=%b/%h/%h exp=1/%h/%h", nm,
                 wbm_cyc_o, wbm_adr_o, wbm_dat_o, ea, ed);
      end
    end
    wbm_ack_i = 1'b1;
    step();
    wbm_ack_i = 1'b0;
    dma_irq_i = 1'b0;
    total++;
    if (wbm_cyc_o !== 1'b0 || done_o !== 4'b0) begin
      bad++;
      $display("FAIL %s_drop got cyc=%b done=%b exp cyc=0 done=0", nm,
               wbm_cyc_o, done_o);
    end
  endtask

  task automatic run_xfer(input logic [3:0] req, input bit hold,
                          input bit rnd, input int dly, input bit to,
                          input int irq_after, input bit stray,
                          input bit drop);
    int w, n;
    logic [3:0] oh;
    logic [31:0] e_rd, e_wr, e_go;
    if (rnd) rand_fields(); else drive_fields();
    req_i = req;
    w = pick(req);
    n = 0;
    while (!busy_o && n < 8) begin
      step();
      n++;
    end
    total++;
    if (!busy_o) begin
      bad++;
      $display("FAIL grant_wait got busy=0 exp busy=1");
      req_i = '0;
      return;
    end
    total++;
    if (gnt_idx_o !== 3'(w))
      begin bad++; $display("FAIL grant got=%0d exp=%0d", gnt_idx_o, w); end
    ptr = (w + 1) % 4;
    oh = 4'(1) << w;
    e_rd = (32'(f_rdv[w]) << 30) | 32'(f_rda[w]);
    e_wr = (32'(f_wrv[w]) << 30) | 32'(f_wra[w]);
    e_go = 32'h8000_0000 | 32'(f_cnt[w]);
    if (drop) req_i[w] = 1'b0;
    if (rnd) rand_fields();
    serve_write(0, dly, stray, 16'h0, e_rd, "rd");
    serve_write(1, dly, stray, 16'h4, e_wr, "wr");
    serve_write(1, dly, stray, 16'h8, e_go, "go");
    if (!to) begin
      repeat (irq_after) step();
      dma_irq_i = 1'b1;
      step();
      dma_irq_i = 1'b0;
      total++;
      if ({done_o, err_o, busy_o, wbm_cyc_o} !== {oh, 4'b0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL done got d=%b e=%b b=%b c=%b exp d=%b e=0000 b=0 c=0",
                 done_o, err_o, busy_o, wbm_cyc_o, oh);
      end
    end else begin
      n = 0;
      while (err_o == 4'b0 && n < 40) begin
        step();
        n++;
      end
      total++;
      if (n !== TO || err_o !== oh || done_o !== 4'b0 || busy_o !== 1'b0) begin
        bad++;
        $display("FAIL timeout got n=%0d e=%b d=%b b=%b exp n=%0d e=%b d=0000 b=0",
                 n, err_o, done_o, busy_o, TO, oh);
      end
    end
    if (!hold) req_i[w] = 1'b0;
    step();
    total++;
    if (done_o !== 4'b0 || err_o !== 4'b0) begin
      bad++;
      $display("FAIL pulse_len got d=%b e=%b exp 0000/0000", done_o, err_o);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1; req_i = '0; wbm_ack_i = 1'b0; dma_irq_i = 1'b0;
    rd_dev_i = '0; wr_dev_i = '0; rd_adr_i = '0; wr_adr_i = '0; count_i = '0;
    repeat (3) step();
    total++;
    if ({done_o, err_o, busy_o, gnt_idx_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
         wbm_sel_o, wbm_adr_o, wbm_dat_o} !== '0) begin
      bad++;
      $display("FAIL reset got d=%b e=%b b=%b g=%0d c=%b a=%h dt=%h exp all 0",
               done_o, err_o, busy_o, gnt_idx_o, wbm_cyc_o, wbm_adr_o,
               wbm_dat_o);
    end
    rst_i = 1'b0;
    ptr = 0;
    step();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 5; i++)
      run_xfer(4'hF, 1'b1, 1'b1, 0, 1'b0, 2, 1'b0, 1'b0);
    req_i = '0;
  endtask

  task automatic test_single;
    f_rdv[1] = 2'd2; f_rda[1] = 7'h10;
    f_wrv[1] = 2'd3; f_wra[1] = 7'h20;
    f_cnt[1] = 8'd8;
    run_xfer(4'b0010, 1'b0, 1'b0, 0, 1'b0, 3, 1'b0, 1'b0);
  endtask

  task automatic test_ack_delay;
    run_xfer(4'b0101, 1'b0, 1'b1, 3, 1'b0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    run_xfer(4'b0100, 1'b0, 1'b1, 1, 1'b1, 0, 1'b0, 1'b0);
    run_xfer(4'b0001, 1'b0, 1'b1, 0, 1'b0, 4, 1'b0, 1'b0);
  endtask

  task automatic test_stray_and_drop;
    req_i = '0;
    dma_irq_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (done_o !== 4'b0 || busy_o !== 1'b0) begin
        bad++;
        $display("FAIL stray_idle got d=%b b=%b exp 0000/0", done_o, busy_o);
      end
    end
    dma_irq_i = 1'b0;
    step();
    run_xfer(4'b1000, 1'b0, 1'b1, 1, 1'b0, 2, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid;
    int w;
    rand_fields();
    req_i = 4'b0100;
    w = pick(req_i);
    step();
    total++;
    if (busy_o !== 1'b1)
      begin bad++; $display("FAIL mid_grant got busy=%b exp 1", busy_o); end
    serve_write(0, 0, 1'b0, 16'h0, (32'(f_rdv[w]) << 30) | 32'(f_rda[w]), "mrd");
    serve_write(1, 0, 1'b0, 16'h4, (32'(f_wrv[w]) << 30) | 32'(f_wra[w]), "mwr");
    serve_write(1, 0, 1'b0, 16'h8, 32'h8000_0000 | 32'(f_cnt[w]), "mgo");
    step();
    step();
    rst_i = 1'b1;
    req_i = '0;
    step();
    total++;
    if ({busy_o, wbm_cyc_o, done_o, err_o, gnt_idx_o} !== '0) begin
      bad++;
      $display("FAIL mid_reset got b=%b c=%b d=%b e=%b g=%0d exp all 0",
               busy_o, wbm_cyc_o, done_o, err_o, gnt_idx_o);
    end
    rst_i = 1'b0;
    ptr = 0;
    step();
    dma_irq_i = 1'b1;
    step();
    dma_irq_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (done_o !== 4'b0 || busy_o !== 1'b0) begin
        bad++;
        $display("FAIL late_irq got d=%b b=%b exp 0000/0", done_o, busy_o);
      end
      step();
    end
    run_xfer(4'b1010, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 14; i++)
      run_xfer(4'($urandom_range(1, 15)), 1'b0, 1'b1,
               $urandom_range(0, 3), ($urandom % 6) == 0,
               $urandom_range(0, 10), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_ack_delay();
    test_timeout();
    test_stray_and_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog");
  end

endmodule
